// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: elastic in-order pipeline with bubble collapse, redirect flush, valid/ready ends.
// Optional perf counters enabled by defining PIPE_PERF_EN.
module pipe_flow_ctrl #(
  parameter int STAGES      = 5,
  parameter int WIDTH       = 32,
  parameter int FLUSH_STAGE = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [STAGES-1:0]               hold_req,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [STAGES-1:0]               stage_valid,
  output logic [STAGES*WIDTH-1:0]         stage_data,
  output logic [$clog2(STAGES+1)-1:0]     occupancy,
  output logic [31:0]                     perf_bubbles,
  output logic [31:0]                     perf_flushes
);
  localparam int OW = $clog2(STAGES+1);
  logic [STAGES-1:0] valid, adv, fill, nxt_valid;
  logic [STAGES:0] acc;
  logic [STAGES-1:0][WIDTH-1:0] data, src;
  logic [OW-1:0] cnt;
  assign src = {data[STAGES-2:0], in_data};
  // acc[i] walks from the output end so a held older slot still lets younger ones close gaps
  always_comb begin
    acc = '0;
    adv = '0;
    acc[STAGES] = out_ready;
    for (int i = STAGES-1; i >= 0; i--) begin
      adv[i] = valid[i] & ~hold_req[i] & acc[i+1];
      acc[i] = ~valid[i] | adv[i];
    end
    fill = {adv[STAGES-2:0], in_valid & acc[0] & ~flush};
    nxt_valid = fill | (valid & ~adv);
    if (flush) begin
      nxt_valid[FLUSH_STAGE-1:0] = '0;
      nxt_valid[FLUSH_STAGE] = adv[FLUSH_STAGE-1] ? 1'b0 : nxt_valid[FLUSH_STAGE];
    end
    cnt = '0;
    for (int i = 0; i < STAGES; i++) cnt = cnt + OW'(nxt_valid[i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= '0;
      data      <= '0;
      occupancy <= '0;
    end else begin
      valid     <= nxt_valid;
      occupancy <= cnt;
      for (int i = 0; i < STAGES; i++) if (fill[i]) data[i] <= src[i];
    end
  end
  assign in_ready    = acc[0] & ~flush;
  assign out_valid   = valid[STAGES-1] & ~hold_req[STAGES-1];
  assign out_data    = data[STAGES-1];
  assign stage_valid = valid;
  assign stage_data  = data;
`ifdef PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else begin
      if (!out_valid && !(&perf_bubbles)) perf_bubbles <= perf_bubbles + 32'd1;
      if (flush && !(&perf_flushes)) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`else
  assign perf_bubbles = '0;
  assign perf_flushes = '0;
`endif
endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Parametrised in-order pipeline flow controller: a chain of STAGES payload registers with per-stage valid bits, stall-aware elastic advance (bubble collapse), a redirect flush that squashes younger stages, and a valid/ready boundary at both ends. It replaces the fixed, unconditionally-advancing inter-stage registers of the 5-stage core, so the core can insert load-use holds and branch squashes without per-register glue. Stage 0 is youngest (IF side); stage STAGES-1 is oldest (WB side).

## Interface
- STAGES, 5, number of pipeline register slots (≥2)
- WIDTH, 32, payload bits per slot
- FLUSH_STAGE, 3, stage whose redirect squashes stages 0..FLUSH_STAGE-1 (1 ≤ FLUSH_STAGE ≤ STAGES-1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream offers payload
- in_ready  out  1  slot 0 can accept this cycle
- in_data  in  WIDTH  upstream payload
- hold_req  in  STAGES  bit i: stage i may not pass its entry onward this cycle
- flush  in  1  redirect from the entry in stage FLUSH_STAGE
- out_valid  out  1  oldest entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  oldest payload
- stage_valid  out  STAGES  per-slot valid
- stage_data  out  STAGES*WIDTH  per-slot payload, slot i at [i*WIDTH +: WIDTH]
- occupancy  out  $clog2(STAGES+1)  count of valid slots
- perf_bubbles  out  32  cycles with out_valid=0 (see Configuration)
- perf_flushes  out  32  flush events (see Configuration)

## Operation
- adv[last] = valid[last] & ~hold_req[last] & out_ready; adv[i] = valid[i] & ~hold_req[i] & acc[i+1]; acc[i] = ~valid[i] | adv[i]. Combinational chain, no registered skid.
- in_ready = acc[0] & ~flush. out_valid = valid[last] & ~hold_req[last]; out_data = data[last].
- Slot i+1 loads data[i] when adv[i]; slot 0 loads in_data on in_valid & in_ready. A slot that empties without refill clears valid; its data is left unchanged.
- Bubble collapse: an entry advances into an empty slot even while an older stage is held.
- hold_req on an invalid slot is ignored.
- Flush (evaluated in the same cycle as the advance): at the edge, valid[0..FLUSH_STAGE-1] ← 0. Any entry moving from stage FLUSH_STAGE-1 into stage FLUSH_STAGE is squashed, so stage FLUSH_STAGE receives a bubble. The flushing entry and all older stages advance normally. No input is accepted during flush.
- flush asserted while valid[FLUSH_STAGE]=0 is still honoured; it is caller's error, not detected.
- occupancy = popcount(stage_valid), registered alongside valid.
- Reset: all valid, data, occupancy, perf counters ← 0; in_ready=1 and out_valid=0 in the first cycle after reset.

## Timing
- Min latency: an entry accepted at edge N is on out_valid after edge N+STAGES-1, i.e. presented in cycle N+STAGES-1 with no holds.
- Throughput: 1 entry/cycle with no holds and out_ready=1.
- in_ready depends combinationally on out_ready and hold_req. Only the data and valid registers break paths.
- Simultaneous flush and out transfer: the out transfer completes; the flush affects younger slots only.
- Simultaneous hold_req[FLUSH_STAGE] and flush: the flushing entry stays, younger slots are cleared, and stage FLUSH_STAGE does not take a squashed bubble.
- Reset asserted mid-stream overrides flush, hold and handshakes on that edge.

## Configuration
- PIPE_PERF_EN defined: perf_bubbles increments each cycle out_valid=0 (not during reset), and perf_flushes increments each cycle flush=1. Both are 32-bit, saturate at 0xFFFF_FFFF, and reset to 0.
- PIPE_PERF_EN undefined: no counter flops; perf_bubbles and perf_flushes tied to 0. Ports remain.

## Test plan
- Streaming: STAGES=5, in_valid=1 with data 1,2,3…, out_ready=1, holds 0. Required: first out_data=1 four cycles after acceptance, then one entry per cycle, occupancy=5 in steady state.
- Backpressure: fill with 0xA..0xE, out_ready=0 for 3 cycles. Required: in_ready=0, data held, occupancy=5. Release: 0xA..0xE emerge in order, no loss or duplicate.
- Bubble collapse: hold_req[3]=1 for 4 cycles with continuous input. Required: slots 0–2 fill behind the held entry, in_ready falls only when slots 0–3 are all valid, and the order is preserved.
- Flush: full pipe 10..14 (slot 0=14), flush=1 for one cycle, FLUSH_STAGE=3. Required: slots 0–2 invalid next cycle, slot 4 holds 11, slot 3 is a bubble, outputs 10 then 11 only, and perf_flushes=1 when PIPE_PERF_EN is defined.
- Reset mid-stream: assert reset with 3 valid entries. Required: next cycle stage_valid=0, occupancy=0, out_valid=0, in_ready=1, and perf counters 0.
